bsg_dmc_multi_clk_div_rst_seq: RTL and testbench
================================================

Name: bsg_dmc_multi_clk_div_rst_seq

Overview:
- Parametrised clock-divider and reset-sequencer for the DMC clock tree. Generalises the fixed 2X->1X downsampler to num_clk_p independently programmable divided clocks.
- Adds a post-reset hold and staggered per-channel reset release.
- Adds glitch-free runtime ratio changes, applied only at period boundaries through a valid/ready config port.
- Sits between the 2x DFI clock source and the DFI/monitor clock consumers.

Parameters:
- num_clk_p, 2: number of divided clock channels (1..16).
- width_p, 4: divide-field width.
- default_div_p, 0: divide value loaded into every channel at reset. 0 gives clk_i/2.
- rst_hold_cycles_p, 16: cycles all resets stay asserted after the reset synchroniser releases (>=1).
- rst_stagger_p, 4: cycles between consecutive channel reset releases (>=1).

Ports:
- clk_i  in  1  single clock (the 2x DFI clock).
- async_reset_n_i  in  1  asynchronous, active-low reset.
- cfg_v_i  in  1  config request valid.
- cfg_id_i  in  max(1,$clog2(num_clk_p))  target channel.
- cfg_en_i  in  1  channel enable (0 holds that clock low).
- cfg_div_i  in  width_p  divide value d. Output period is 2*(d+1) clk_i cycles.
- cfg_ready_o  out  1  config accept. A transfer happens when cfg_v_i & cfg_ready_o on a rising edge.
- clk_o  out  num_clk_p  registered divided clocks.
- reset_o  out  num_clk_p  active-high per-channel resets, deasserted synchronously to clk_i.
- locked_o  out  1  sequence complete, all resets released.

Behaviour:
- Async assert (async_reset_n_i=0), effective immediately:
  - clk_o=0, reset_o=all ones, locked_o=0, cfg_ready_o=0.
  - All channels enabled with div=default_div_p; counters=0; pending flags=0.
  - State=SYNC.
- Reset synchroniser: 2-flop, async-cleared. The sync output rises on the 2nd rising edge after deassert. The state machine leaves SYNC on that edge.
- State machine SYNC -> HOLD -> RELEASE -> DONE, using one sequence counter of width $clog2(rst_hold_cycles_p+num_clk_p*rst_stagger_p+1).
  - SYNC: divided clocks stopped (held 0).
  - HOLD: divided clocks run; resets held for rst_hold_cycles_p cycles.
  - RELEASE: reset_o[0] falls on the first RELEASE edge. reset_o[k] falls k*rst_stagger_p edges later.
  - DONE: entered on the same edge reset_o[num_clk_p-1] falls; locked_o=1 from that edge. DONE is absorbing until the next async reset.
- Divider, per enabled channel:
  - Down counter loads d when clk_o toggles, decrements otherwise.
  - clk_o toggles on the edge where the counter is 0. High and low phases are each d+1 cycles; duty is 50%.
  - First toggle (0->1) occurs d+1 edges after HOLD entry.
  - A disabled channel has clk_o=0 and counter=0.
- Config port:
  - cfg_ready_o = (state!=SYNC) & ~pending[cfg_id_i].
  - A transfer writes {en,div} into that channel's shadow register and sets pending.
  - cfg_id_i>=num_clk_p: ready=1 when state!=SYNC, and the transfer is dropped with no effect.
- Pending apply:
  - Running channel: applied on the edge where clk_o falls 1->0. The counter loads the new d (or the channel stops if en=0); pending clears on the same edge. No short high or low phase is ever produced.
  - Disabled channel: applied on the next edge. When enabled, the first rise comes d+1 edges after apply.
- Simultaneous events:
  - A pending flag cannot be rewritten while set, because ready is low.
  - Apply and new acceptance on different channels in the same cycle are independent.
  - Configuration accepted during HOLD or RELEASE is honoured; reset timing is unaffected.
- Reset mid-operation: async assert overrides everything in the same instant, pending updates are discarded, and the full sequence restarts.
- reset_o and locked_o are glitch-free because they are driven directly from flops.

Decomposition:
- bsg_dmc_pkg gains:
  - a state enum (SYNC, HOLD, RELEASE, DONE);
  - a struct bsg_dmc_clk_div_cfg_s {en, div[width_p]}, declared via a macro for width.
- One natural sub-module, bsg_dmc_clk_div_chan: a single divider channel with counter, shadow register, pending flag and apply logic. It is instantiated num_clk_p times; the sequencer stays in the top module.

Test Plan:
- Reset release with defaults (num_clk_p=2, hold=16, stagger=4, div=0):
  - deassert async_reset_n_i -> reset_o[0] falls 18 edges later, reset_o[1] falls 22 edges later;
  - locked_o=1 on the edge reset_o[1] falls;
  - clk_o toggles every cycle from HOLD+1.
- Ratio change: channel 0 at d=0 in DONE; program d=2 -> change takes effect at the next clk_o[0] fall, then 3 cycles high and 3 cycles low; no phase shorter than 1 cycle at the transition.
- Back-pressure: two configs to channel 1 on back-to-back cycles -> the second sees cfg_ready_o=0 until the first applies; a config to channel 0 in the same window is accepted.
- Disable/enable: send en=0 to channel 1 -> clk_o[1] goes low at its next fall and stays low; then send en=1, d=1 -> first rise 2 edges after apply.
- Mid-operation reset: assert async_reset_n_i while in RELEASE with a pending update -> all outputs go to reset values immediately, pending is discarded, and the full 18/22-edge sequence repeats after deassert.
- Out-of-range id (num_clk_p=3): cfg_id_i=3 is accepted with ready=1 and has no effect on any channel.

Source files
------------

// File: rtl/bsg_dmc_pkg.sv
// Shared types for the DMC clock-divider / reset-sequencer.
//   bsg_dmc_rst_seq_state_e    : reset sequencer states
//   `BSG_DMC_CLK_DIV_CFG_S(w)  : declares the per-channel {en, div} config
//                                struct bsg_dmc_clk_div_cfg_s for a divide
//                                field of width w
//   bsg_dmc_id_width()         : width of a channel-select field

`ifndef BSG_DMC_CLK_DIV_CFG_S_MACRO
`define BSG_DMC_CLK_DIV_CFG_S_MACRO
`define BSG_DMC_CLK_DIV_CFG_S(width) \
  typedef struct packed { \
    logic               en; \
    logic [(width)-1:0] div; \
  } bsg_dmc_clk_div_cfg_s;
`endif

package bsg_dmc_pkg;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } bsg_dmc_rst_seq_state_e;

  // A single channel still gets a 1-bit select so the port never collapses.
  function automatic int bsg_dmc_id_width(input int num_clk);
    return (num_clk > 1) ? $clog2(num_clk) : 1;
  endfunction

endpackage

// File: rtl/bsg_dmc_clk_div_chan.sv
// One divided-clock channel: down counter, active and shadow {en,div},
// pending flag and the logic that applies a shadow update only at a
// period boundary.
//   clk_i, async_reset_n_i : clock and async active-low reset
//   run_i                  : divider allowed to run (sequencer out of SYNC)
//   start_i                : one-cycle pulse on the edge leaving SYNC
//   cfg_we_i               : accepted config for this channel
//   cfg_en_i, cfg_div_i    : config payload
//   clk_o                  : registered divided clock
//   pending_o              : a shadow update is waiting to be applied

module bsg_dmc_clk_div_chan #(
  parameter int width_p       = 4,
  parameter int default_div_p = 0
) (
  input  logic               clk_i,
  input  logic               async_reset_n_i,
  input  logic               run_i,
  input  logic               start_i,
  input  logic               cfg_we_i,
  input  logic               cfg_en_i,
  input  logic [width_p-1:0] cfg_div_i,
  output logic               clk_o,
  output logic               pending_o
);

  `BSG_DMC_CLK_DIV_CFG_S(width_p)

  localparam logic [width_p-1:0] default_div_lp = width_p'(default_div_p);

  bsg_dmc_clk_div_cfg_s active_q, active_d;
  bsg_dmc_clk_div_cfg_s shadow_q, shadow_d;
  logic [width_p-1:0]   cnt_q, cnt_d;
  logic                 clk_q, clk_d;
  logic                 pend_q, pend_d;

  always_comb begin
    active_d = active_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    clk_d    = clk_q;
    pend_d   = pend_q;

    if (start_i) begin
      // Preload so the first rise lands d+1 edges after the sequencer starts.
      clk_d = 1'b0;
      cnt_d = active_q.en ? active_q.div : '0;
    end else if (!run_i) begin
      clk_d = 1'b0;
      cnt_d = '0;
    end else if (!active_q.en) begin
      clk_d = 1'b0;
      cnt_d = '0;
      if (pend_q) begin
        active_d = shadow_q;
        pend_d   = 1'b0;
        cnt_d    = shadow_q.en ? shadow_q.div : '0;
      end
    end else if (cnt_q == '0) begin
      clk_d = ~clk_q;
      cnt_d = active_q.div;
      // Only swap ratios on the falling edge: the high phase just ended at
      // full length and the new low phase starts fresh at the new length.
      if (clk_q && pend_q) begin
        active_d = shadow_q;
        pend_d   = 1'b0;
        cnt_d    = shadow_q.en ? shadow_q.div : '0;
      end
    end else begin
      cnt_d = cnt_q - 1'b1;
    end

    // Ready is low while pending, so this never races the apply above.
    if (cfg_we_i) begin
      shadow_d.en  = cfg_en_i;
      shadow_d.div = cfg_div_i;
      pend_d       = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      active_q <= '{en: 1'b1, div: default_div_lp};
      shadow_q <= '{en: 1'b1, div: default_div_lp};
      cnt_q    <= '0;
      clk_q    <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      clk_q    <= clk_d;
      pend_q   <= pend_d;
    end
  end

  assign clk_o     = clk_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/bsg_dmc_multi_clk_div_rst_seq.sv
// Multi-channel clock divider with post-reset hold and staggered per-channel
// reset release. Runtime ratio changes arrive through a valid/ready port and
// are applied glitch-free at period boundaries.
//   clk_i, async_reset_n_i : 2x DFI clock, async active-low reset
//   cfg_v_i / cfg_ready_o  : config handshake
//   cfg_id_i               : target channel (out-of-range ids are dropped)
//   cfg_en_i, cfg_div_i    : enable and divide value (period 2*(d+1))
//   clk_o                  : divided clocks
//   reset_o                : active-high per-channel resets
//   locked_o               : all resets released
//
// state   | meaning
// --------+-----------------------------------------------------------
// SYNC    | waiting for the reset synchroniser; divided clocks held low
// HOLD    | clocks running, every reset still asserted
// RELEASE | resets dropping one channel every rst_stagger_p cycles
// DONE    | all resets released, locked_o high until next async reset

module bsg_dmc_multi_clk_div_rst_seq
  import bsg_dmc_pkg::*;
#(
  parameter int num_clk_p         = 2,
  parameter int width_p           = 4,
  parameter int default_div_p     = 0,
  parameter int rst_hold_cycles_p = 16,
  parameter int rst_stagger_p     = 4
) (
  input  logic                                   clk_i,
  input  logic                                   async_reset_n_i,
  input  logic                                   cfg_v_i,
  input  logic [bsg_dmc_id_width(num_clk_p)-1:0] cfg_id_i,
  input  logic                                   cfg_en_i,
  input  logic [width_p-1:0]                     cfg_div_i,
  output logic                                   cfg_ready_o,
  output logic [num_clk_p-1:0]                   clk_o,
  output logic [num_clk_p-1:0]                   reset_o,
  output logic                                   locked_o
);

  localparam int id_w_lp  = bsg_dmc_id_width(num_clk_p);
  localparam int seq_w_lp = $clog2(rst_hold_cycles_p + num_clk_p*rst_stagger_p + 1);

  // The sequence counter runs down from here to 0; reset_o[k] drops when it
  // reads (num_clk_p-1-k)*rst_stagger_p, so channel 0 drops exactly
  // rst_hold_cycles_p cycles after HOLD entry and the last one at 0.
  localparam logic [seq_w_lp-1:0] seq_load_lp =
    seq_w_lp'(rst_hold_cycles_p - 1 + (num_clk_p - 1)*rst_stagger_p);
  localparam logic [seq_w_lp-1:0] seq_rel_lp =
    seq_w_lp'((num_clk_p - 1)*rst_stagger_p);

  bsg_dmc_rst_seq_state_e state_q, state_d;
  logic [seq_w_lp-1:0]    seq_cnt_q, seq_cnt_d;
  logic                   sync1_q, sync2_q;
  logic [num_clk_p-1:0]   reset_q, reset_d;
  logic                   locked_q, locked_d;
  logic                   seq_start;
  logic [num_clk_p-1:0]   pending;
  logic [num_clk_p-1:0]   chan_we;
  logic                   sel_pending;

  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= 1'b1;
      sync2_q <= sync1_q;
    end
  end

  // Leaves SYNC on the same edge sync2_q rises, so sync2_q doubles as
  // "state != SYNC" for the channels and the ready logic.
  always_comb begin
    state_d   = state_q;
    seq_cnt_d = seq_cnt_q;
    seq_start = 1'b0;
    unique case (state_q)
      SYNC: begin
        if (sync1_q) begin
          state_d   = HOLD;
          seq_cnt_d = seq_load_lp;
          seq_start = 1'b1;
        end
      end
      HOLD, RELEASE: begin
        if (seq_cnt_q == '0) begin
          state_d = DONE;
        end else begin
          seq_cnt_d = seq_cnt_q - 1'b1;
          if (state_q == HOLD && seq_cnt_q == seq_rel_lp) begin
            state_d = RELEASE;
          end
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = SYNC;
      end
    endcase
  end

  always_comb begin
    reset_d = reset_q;
    for (int k = 0; k < num_clk_p; k++) begin
      if ((state_q == HOLD || state_q == RELEASE) &&
          seq_cnt_q == seq_w_lp'((num_clk_p - 1 - k)*rst_stagger_p)) begin
        reset_d[k] = 1'b0;
      end
    end
    locked_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      state_q   <= SYNC;
      seq_cnt_q <= '0;
      reset_q   <= '1;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_cnt_q <= seq_cnt_d;
      reset_q   <= reset_d;
      locked_q  <= locked_d;
    end
  end

  // An id with no matching channel selects no pending bit, so it reads ready
  // and its write enable matches nothing: the transfer is silently dropped.
  always_comb begin
    sel_pending = 1'b0;
    for (int k = 0; k < num_clk_p; k++) begin
      if (cfg_id_i == id_w_lp'(k)) begin
        sel_pending = pending[k];
      end
    end
  end

  assign cfg_ready_o = sync2_q & ~sel_pending;

  always_comb begin
    chan_we = '0;
    for (int k = 0; k < num_clk_p; k++) begin
      chan_we[k] = cfg_v_i & cfg_ready_o & (cfg_id_i == id_w_lp'(k));
    end
  end

  for (genvar k = 0; k < num_clk_p; k++) begin : g_chan
    bsg_dmc_clk_div_chan #(
      .width_p      (width_p),
      .default_div_p(default_div_p)
    ) u_chan (
      .clk_i          (clk_i),
      .async_reset_n_i(async_reset_n_i),
      .run_i          (sync2_q),
      .start_i        (seq_start),
      .cfg_we_i       (chan_we[k]),
      .cfg_en_i       (cfg_en_i),
      .cfg_div_i      (cfg_div_i),
      .clk_o          (clk_o[k]),
      .pending_o      (pending[k])
    );
  end

  assign reset_o  = reset_q;
  assign locked_o = locked_q;

endmodule

// File: tb/tb_bsg_dmc_multi_clk_div_rst_seq.sv
module tb_bsg_dmc_multi_clk_div_rst_seq;

  localparam int N    = 2;
  localparam int W    = 4;
  localparam int HOLD = 16;
  localparam int STAG = 4;

  logic clk_i;
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic         rst_n;
  logic         cfg_v, cfg_en, ready, locked;
  logic [0:0]   cfg_id;
  logic [W-1:0] cfg_div;
  logic [N-1:0] clk_o, reset_o;

  logic         cfg_v3, cfg_en3, ready3, locked3;
  logic [1:0]   cfg_id3;
  logic [W-1:0] cfg_div3;
  logic [2:0]   clk3, reset3;

  bsg_dmc_multi_clk_div_rst_seq #(
    .num_clk_p(N), .width_p(W), .default_div_p(0),
    .rst_hold_cycles_p(HOLD), .rst_stagger_p(STAG)
  ) dut (
    .clk_i(clk_i), .async_reset_n_i(rst_n), .cfg_v_i(cfg_v), .cfg_id_i(cfg_id),
    .cfg_en_i(cfg_en), .cfg_div_i(cfg_div), .cfg_ready_o(ready),
    .clk_o(clk_o), .reset_o(reset_o), .locked_o(locked)
  );

  bsg_dmc_multi_clk_div_rst_seq #(
    .num_clk_p(3), .width_p(W), .default_div_p(0),
    .rst_hold_cycles_p(HOLD), .rst_stagger_p(STAG)
  ) dut3 (
    .clk_i(clk_i), .async_reset_n_i(rst_n), .cfg_v_i(cfg_v3), .cfg_id_i(cfg_id3),
    .cfg_en_i(cfg_en3), .cfg_div_i(cfg_div3), .cfg_ready_o(ready3),
    .clk_o(clk3), .reset_o(reset3), .locked_o(locked3)
  );

  int errors = 0;
  int checks = 0;
  bit chk_on = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // Behavioural model: m_e counts rising edges since reset deassert. Each
  // channel is tracked as a level plus the absolute edge of its next toggle.
  int  m_e;
  bit  m_en   [N];
  int  m_d    [N];
  bit  m_lvl  [N];
  int  m_nt   [N];
  bit  m_pend [N];
  bit  m_sen  [N];
  int  m_sd   [N];
  bit  m_acc;
  int  m_aid;

  function automatic bit m_ready(input int id);
    if (m_e < 2) return 1'b0;
    if (id >= N) return 1'b1;
    return !m_pend[id];
  endfunction

  task automatic m_apply(input int k);
    m_en[k]   = m_sen[k];
    m_d[k]    = m_sd[k];
    m_pend[k] = 1'b0;
    m_lvl[k]  = 1'b0;
    m_nt[k]   = m_e + m_d[k] + 1;
  endtask

  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      m_e = 0;
      for (int k = 0; k < N; k++) begin
        m_en[k] = 1'b1; m_d[k] = 0; m_lvl[k] = 1'b0; m_nt[k] = 0; m_pend[k] = 1'b0;
      end
    end else begin
      m_aid = int'(cfg_id);
      m_acc = cfg_v && m_ready(m_aid);
      m_e++;
      for (int k = 0; k < N; k++) begin
        if (m_e == 2) begin
          if (m_en[k]) m_nt[k] = m_e + m_d[k] + 1;
        end else if (m_e > 2) begin
          if (m_en[k]) begin
            if (m_e == m_nt[k]) begin
              m_lvl[k] = !m_lvl[k];
              if (!m_lvl[k] && m_pend[k]) m_apply(k);
              else m_nt[k] = m_e + m_d[k] + 1;
            end
          end else if (m_pend[k]) begin
            m_apply(k);
          end
        end
      end
      if (m_acc && m_aid < N) begin
        m_sen[m_aid]  = cfg_en;
        m_sd[m_aid]   = int'(cfg_div);
        m_pend[m_aid] = 1'b1;
      end
    end
  end

  always @(negedge clk_i) begin
    if (chk_on) begin
      for (int k = 0; k < N; k++) begin
        check("clk_o", int'(clk_o[k]), int'(m_lvl[k]));
        check("reset_o", int'(reset_o[k]), (m_e >= 2 + HOLD + k*STAG) ? 0 : 1);
      end
      check("locked_o", int'(locked), (m_e >= 2 + HOLD + (N-1)*STAG) ? 1 : 0);
      check("cfg_ready_o", int'(ready), int'(m_ready(int'(cfg_id))));
    end
  end

  task automatic send(input int id, input bit en, input int d);
    bit r;
    bit done;
    done = 1'b0;
    @(posedge clk_i); #2;
    cfg_v = 1'b1; cfg_id = 1'(id); cfg_en = en; cfg_div = W'(d);
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk_i); r = ready;
      @(posedge clk_i); if (r) done = 1'b1;
    end
    #2 cfg_v = 1'b0;
    check("send_accepted", int'(done), 1);
  endtask

  task automatic wait_e(input int target);
    int g;
    g = 0;
    while (m_e < target && g < 100) begin
      @(posedge clk_i); #1; g++;
    end
    check("wait_e_reached", int'(m_e >= target), 1);
  endtask

  task automatic measure_seq(output int t_r0, output int t_r1, output int t_lk,
                             output int t_c0a, output int t_c0b, output int t_lk3);
    int  rises;
    bit  prev;
    t_r0 = -1; t_r1 = -1; t_lk = -1; t_c0a = -1; t_c0b = -1; t_lk3 = -1;
    rises = 0; prev = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk_i); #1;
      if (t_r0 < 0 && !reset_o[0]) t_r0 = i;
      if (t_r1 < 0 && !reset_o[1]) t_r1 = i;
      if (t_lk < 0 && locked) t_lk = i;
      if (t_lk3 < 0 && locked3) t_lk3 = i;
      if (clk_o[0] && !prev) begin
        rises++;
        if (rises == 1) t_c0a = i;
        if (rises == 2) t_c0b = i;
      end
      prev = clk_o[0];
    end
  endtask

  task automatic measure_runs(input int ch, output int lo, output int hi);
    bit s [24];
    int i;
    s[0] = clk_o[ch];
    for (int j = 1; j < 24; j++) begin
      @(posedge clk_i); #1; s[j] = clk_o[ch];
    end
    lo = 0; hi = 0; i = 1;
    while (i < 24 && !(s[i-1] && !s[i])) i++;
    while (i < 24 && !s[i]) begin lo++; i++; end
    while (i < 24 && s[i]) begin hi++; i++; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t_r0, t_r1, t_lk, t_c0a, t_c0b, t_lk3, lo, hi, tog, lows, rise_at;
    logic [2:0] prev3;

    rst_n = 1'b1; cfg_v = 1'b0; cfg_id = '0; cfg_en = 1'b1; cfg_div = '0;
    cfg_v3 = 1'b0; cfg_id3 = '0; cfg_en3 = 1'b1; cfg_div3 = '0;
    #1 rst_n = 1'b0;
    #1 chk_on = 1'b1;
    check("rst_clk_o", int'(clk_o), 0);
    check("rst_reset_o", int'(reset_o), 3);
    check("rst_locked", int'(locked), 0);
    check("rst_ready", int'(ready), 0);

    repeat (3) @(posedge clk_i);
    #2 rst_n = 1'b1;
    measure_seq(t_r0, t_r1, t_lk, t_c0a, t_c0b, t_lk3);
    check("release_edge_ch0", t_r0, 18);
    check("release_edge_ch1", t_r1, 22);
    check("locked_edge", t_lk, 22);
    check("first_rise_ch0", t_c0a, 3);
    check("second_rise_ch0", t_c0b, 5);
    check("locked_edge_3ch", t_lk3, 26);

    // Out-of-range id on the 3-channel instance
    @(posedge clk_i); #2;
    cfg_v3 = 1'b1; cfg_id3 = 2'd3; cfg_en3 = 1'b0; cfg_div3 = 4'd5;
    @(negedge clk_i);
    check("oor_ready", int'(ready3), 1);
    @(posedge clk_i); #2 cfg_v3 = 1'b0;
    prev3 = clk3; tog = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i); #1;
      for (int c = 0; c < 3; c++) if (clk3[c] != prev3[c]) tog++;
      prev3 = clk3;
    end
    check("oor_toggles", tog, 24);
    check("oor_reset3", int'(reset3), 0);
    check("oor_locked3", int'(locked3), 1);

    // Ratio change on channel 0
    send(0, 1'b1, 2);
    measure_runs(0, lo, hi);
    check("ratio_low_run", lo, 3);
    check("ratio_high_run", hi, 3);

    // Back-pressure on channel 1, channel 0 still accepted
    @(posedge clk_i); #2;
    cfg_v = 1'b1; cfg_id = 1'b1; cfg_en = 1'b1; cfg_div = 4'd1;
    @(negedge clk_i);
    check("bp_first_ready", int'(ready), 1);
    @(posedge clk_i); #2;
    cfg_div = 4'd3;
    @(negedge clk_i);
    check("bp_second_blocked", int'(ready), 0);
    @(posedge clk_i); #2;
    cfg_id = 1'b0; cfg_div = 4'd0;
    @(negedge clk_i);
    check("bp_other_chan_ready", int'(ready), 1);
    @(posedge clk_i); #2 cfg_v = 1'b0;
    send(1, 1'b1, 3);

    // Disable then re-enable channel 1
    send(1, 1'b0, 0);
    repeat (12) @(posedge clk_i);
    #1 lows = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      if (!clk_o[1]) lows++;
    end
    check("disabled_stays_low", lows, 10);
    send(1, 1'b1, 1);
    rise_at = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk_i); #1;
      if (rise_at < 0 && clk_o[1]) rise_at = i;
    end
    check("enable_first_rise", rise_at, 3);

    // Reset in RELEASE with an update pending on channel 0
    @(posedge clk_i); #2 rst_n = 1'b0;
    repeat (2) @(posedge clk_i);
    #2 rst_n = 1'b1;
    wait_e(4);
    send(0, 1'b1, 7);
    wait_e(18);
    send(0, 1'b1, 3);
    #1;
    check("pre_reset_release", int'(reset_o), 2);
    check("pre_reset_locked", int'(locked), 0);
    rst_n = 1'b0;
    #1;
    check("midrst_clk_o", int'(clk_o), 0);
    check("midrst_reset_o", int'(reset_o), 3);
    check("midrst_locked", int'(locked), 0);
    check("midrst_ready", int'(ready), 0);
    repeat (2) @(posedge clk_i);
    #2 rst_n = 1'b1;
    measure_seq(t_r0, t_r1, t_lk, t_c0a, t_c0b, t_lk3);
    check("rerelease_ch0", t_r0, 18);
    check("rerelease_ch1", t_r1, 22);
    check("relocked_edge", t_lk, 22);
    check("rerun_first_rise", t_c0a, 3);
    check("rerun_second_rise", t_c0b, 5);

    repeat (2) @(posedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
